// File: rtl/psum_rd_pkg.sv
// Shared types and sizing helpers for the psum output reader.
package psum_rd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_e;

  localparam int FRAME_CNT_W = 16;

  // Column index width; never collapses to zero bits for a single-column core.
  function automatic int col_idx_w(input int col);
    return (col > 1) ? $clog2(col) : 1;
  endfunction

endpackage

// File: rtl/row_buffer_2.sv
// Two-entry row FIFO holding captured psum rows until they are serialized.
// head is the oldest row; second is the row behind it (valid when count==2).
module row_buffer_2 #(
  parameter int row_w = 152,
  parameter int cnt_w = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [row_w-1:0] push_row,
  input  logic             pop,
  output logic [cnt_w-1:0] count,
  output logic [row_w-1:0] head,
  output logic [row_w-1:0] second
);

  logic [row_w-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (count != cnt_w'(2));
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];
  assign second  = mem[~rd_ptr];

  // Row storage; contents are don't-care until count says otherwise.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_row;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psum_out_reader.sv
// Captures wide psum rows from a core and streams them out one column per cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no row being sent; leave as soon as the buffer holds a row
// SEND  | presenting column ser_col of the head row on the stream
module psum_out_reader
  import psum_rd_pkg::*;
#(
  parameter int col     = 8,
  parameter int bw_psum = 19,
  parameter int depth   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [col*bw_psum-1:0]    out_core,
  input  logic                      cap_valid,
  output logic                      cap_ready,
  output logic [bw_psum-1:0]        ser_data,
  output logic [col_idx_w(col)-1:0] ser_col,
  output logic                      ser_last,
  output logic                      ser_valid,
  input  logic                      ser_ready,
  output logic [FRAME_CNT_W-1:0]    frame_cnt,
  output logic                      overflow
);

  localparam int CW    = col_idx_w(col);
  localparam int RW    = col * bw_psum;
  localparam int CNT_W = $clog2(depth + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(col - 1);

  rd_state_e         state;
  rd_state_e         state_nx;
  logic [CW-1:0]     col_nx;
  logic [RW-1:0]     row_nx;
  logic              valid_nx;
  logic [bw_psum-1:0] data_nx;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  buf_count;
  logic [RW-1:0]     buf_head;
  logic [RW-1:0]     buf_second;

  // A slot freed by this cycle's pop is not reusable until next cycle.
  assign cap_ready = (buf_count < CNT_W'(depth));
  assign push      = cap_valid & cap_ready;

  row_buffer_2 #(
    .row_w (RW),
    .cnt_w (CNT_W)
  ) u_row_buffer (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_row (out_core),
    .pop      (pop),
    .count    (buf_count),
    .head     (buf_head),
    .second   (buf_second)
  );

  // Next state, next column and the row that will be at the head next cycle.
  // On a last-column pop the following row is either the second buffered row
  // or, with only one row held, the row being captured in this same cycle.
  always_comb begin
    state_nx = state;
    col_nx   = ser_col;
    pop      = 1'b0;
    row_nx   = buf_head;
    case (state)
      IDLE: begin
        if (buf_count != '0) begin
          state_nx = SEND;
          col_nx   = '0;
        end
      end
      SEND: begin
        if (ser_ready) begin
          if (ser_col == LAST_COL) begin
            pop    = 1'b1;
            col_nx = '0;
            if (buf_count == CNT_W'(2)) begin
              row_nx = buf_second;
            end else if (push) begin
              row_nx = out_core;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            col_nx = ser_col + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    valid_nx = (state_nx == SEND);
    data_nx  = valid_nx ? row_nx[col_nx*bw_psum +: bw_psum] : '0;
  end

  // State and registered stream outputs; holding under backpressure falls out
  // of col_nx and row_nx staying put.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ser_valid <= 1'b0;
      ser_data  <= '0;
      ser_col   <= '0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_nx;
      ser_valid <= valid_nx;
      ser_data  <= data_nx;
      ser_col   <= col_nx;
      ser_last  <= valid_nx && (col_nx == LAST_COL);
    end
  end

  // Delivered-row counter (wraps) and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (pop) frame_cnt <= frame_cnt + 1'b1;
      if (cap_valid && !cap_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_out_reader.sv
// Scoreboard bench for psum_out_reader: accepted rows queue their expected
// words; a negedge monitor pops and compares on every handshake.
module tb_psum_out_reader;

  localparam int COL = 8;
  localparam int BW  = 19;
  localparam int RW  = COL * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [RW-1:0] out_core = '0;
  logic          cap_valid = 1'b0;
  logic          cap_ready;
  logic [BW-1:0] ser_data;
  logic [2:0]    ser_col;
  logic          ser_last;
  logic          ser_valid;
  logic          ser_ready = 1'b0;
  logic [15:0]   frame_cnt;
  logic          overflow;

  always #5 clk = ~clk;

  psum_out_reader #(.col(COL), .bw_psum(BW), .depth(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .out_core  (out_core),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .ser_data  (ser_data),
    .ser_col   (ser_col),
    .ser_last  (ser_last),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .frame_cnt (frame_cnt),
    .overflow  (overflow)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  logic [22:0] exp_q[$];
  logic [22:0] e;
  int          cyc = 0;
  int          vcyc = 0;
  int          vfirst = 0;
  int          vlast = 0;
  bit          vseen = 0;
  int          words = 0;
  int          ready_mode = 0;
  bit          prev_hold = 0;
  logic [BW-1:0] prev_data;
  logic [2:0]  prev_col;
  logic        prev_last;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: scoreboard compare on handshake plus stability under backpressure.
  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk_eq("hold_valid", 32'(ser_valid), 32'd1);
        chk_eq("hold_data", 32'(ser_data), 32'(prev_data));
        chk_eq("hold_col", 32'(ser_col), 32'(prev_col));
        chk_eq("hold_last", 32'(ser_last), 32'(prev_last));
      end
      if (ser_valid) begin
        vcyc++;
        if (!vseen) begin
          vfirst = cyc;
          vseen  = 1;
        end
        vlast = cyc;
      end
      if (ser_valid && ser_ready) begin
        if (exp_q.size() == 0) begin
          chk_eq("spurious_word", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk_eq("ser_data", 32'(ser_data), 32'(e[18:0]));
          chk_eq("ser_col", 32'(ser_col), 32'(e[21:19]));
          chk_eq("ser_last", 32'(ser_last), 32'(e[22]));
        end
        words++;
      end
      prev_hold = ser_valid && !ser_ready;
      prev_data = ser_data;
      prev_col  = ser_col;
      prev_last = ser_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    vcyc  = 0;
    vseen = 0;
    words = 0;
  endtask

  function automatic logic [RW-1:0] make_row(input int base);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = BW'(base + k);
    return r;
  endfunction

  task automatic do_reset();
    reset     = 1'b0;
    cap_valid = 1'b0;
    ser_ready = 1'b0;
    ready_mode = 0;
    tick();
    tick();
    reset = 1'b1;
    exp_q.delete();
    clear_stats();
  endtask

  task automatic capture(input logic [RW-1:0] row, input bit exp_acc);
    logic [2:0] c;
    out_core  = row;
    cap_valid = 1'b1;
    chk_eq("cap_ready", 32'(cap_ready), 32'(exp_acc));
    if (exp_acc) begin
      for (int k = 0; k < COL; k++) begin
        c = 3'(k);
        exp_q.push_back({(k == COL - 1), c, row[k*BW +: BW]});
      end
    end
    tick();
    cap_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0 && !ser_valid) break;
      if (ready_mode == 1) ser_ready = ~ser_ready;
      tick();
    end
    chk_eq("drain_done", 32'((exp_q.size() == 0) && !ser_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [RW-1:0] r;

    // Reset state
    do_reset();
    chk_eq("rst_ser_valid", 32'(ser_valid), 32'd0);
    chk_eq("rst_cap_ready", 32'(cap_ready), 32'd1);
    chk_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk_eq("rst_overflow", 32'(overflow), 32'd0);
    chk_eq("rst_ser_data", 32'(ser_data), 32'd0);

    // Single row, ready held high; one-cycle capture latency
    ser_ready = 1'b1;
    capture(make_row(1), 1);
    chk_eq("lat_edge_n", 32'(ser_valid), 32'd0);
    tick();
    chk_eq("lat_edge_n1", 32'(ser_valid), 32'd1);
    wait_drain(50);
    chk_eq("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk_eq("t1_valid_cycles", 32'(vcyc), 32'd8);
    chk_eq("t1_span", 32'(vlast - vfirst + 1), 32'd8);

    // Same row under alternating ready
    do_reset();
    ready_mode = 1;
    capture(make_row(1), 1);
    wait_drain(80);
    chk_eq("t2_frame_cnt", 32'(frame_cnt), 32'd1);
    chk_eq("t2_words", 32'(words), 32'd8);
    chk_eq("t2_overflow", 32'(overflow), 32'd0);

    // Back-to-back rows plus a dropped third row
    do_reset();
    ser_ready = 1'b1;
    capture(make_row(1), 1);
    capture(make_row(17), 1);
    capture(make_row(100), 0);
    chk_eq("t3_overflow", 32'(overflow), 32'd1);
    wait_drain(80);
    chk_eq("t3_frame_cnt", 32'(frame_cnt), 32'd2);
    chk_eq("t3_valid_cycles", 32'(vcyc), 32'd16);
    chk_eq("t3_no_bubble_span", 32'(vlast - vfirst + 1), 32'd16);
    chk_eq("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Bit-exact extreme patterns
    do_reset();
    ser_ready = 1'b1;
    r = '1;
    capture(r, 1);
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = (k % 2 == 0) ? 19'h40000 : 19'h00001;
    capture(r, 1);
    wait_drain(80);
    chk_eq("t4_frame_cnt", 32'(frame_cnt), 32'd2);

    // Reset in the middle of a row
    do_reset();
    ser_ready = 1'b1;
    capture(make_row(1), 1);
    capture(make_row(17), 1);
    for (int i = 0; i < 50; i++) begin
      if (words >= 3) break;
      tick();
    end
    chk_eq("t5_words_before_reset", 32'(words), 32'd3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    chk_eq("t5_ser_valid", 32'(ser_valid), 32'd0);
    chk_eq("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    chk_eq("t5_cap_ready", 32'(cap_ready), 32'd1);
    chk_eq("t5_ser_col", 32'(ser_col), 32'd0);
    clear_stats();
    repeat (5) tick();
    chk_eq("t5_quiet", 32'(vcyc), 32'd0);
    capture(make_row(33), 1);
    wait_drain(50);
    chk_eq("t5_restart_frame_cnt", 32'(frame_cnt), 32'd1);
    chk_eq("t5_restart_words", 32'(words), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
